fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: DBIT, 8, number of data bits per frame.
REQ-002 Parameter: SB_TICK, 16, oversampling ticks per stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter: DVSR_W, 11, width of baud divisor input.
REQ-004 Port: clk  input  1  system clock, all state on rising edge.
REQ-005 Port: reset  input  1  reset, asynchronous, active-high.
REQ-006 Port: dvsr  input  DVSR_W  baud divisor; tick period = dvsr+1 clk cycles (16x oversampling).
REQ-007 Port: tx_en  input  1  permits fetching a new byte from the FIFO.
REQ-008 Port: fifo_empty  input  1  empty flag of the upstream FIFO read port.
REQ-009 Port: fifo_rd_data  input  DBIT  word at the FIFO read pointer, valid combinationally while fifo_empty=0.
REQ-010 Port: fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-011 Port: tx  output  1  serial line, idle high, registered.
REQ-012 Port: tx_busy  output  1  high while a frame is in progress.
REQ-013 Port: tx_done_tick  output  1  one-cycle pulse at end of stop period.

Function
REQ-014 Baud generator: free-running counter 0..dvsr, wraps to 0 after dvsr; tick=1 in the cycle the counter equals dvsr; dvsr=0 gives tick every cycle.
REQ-015 FSM states: IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-016 IDLE: fifo_rd = 1 (combinational) iff state=IDLE and fifo_empty=0 and tx_en=1; fifo_rd SHALL never assert in any other state.
REQ-017 On the fifo_rd cycle: shift register <= fifo_rd_data, tick count <= 0, state <= START, tx register <= 0 (line low starting next cycle).
REQ-018 START: after 16 ticks, state <= DATA, bit index <= 0, tx <= shift[0].
REQ-019 DATA: each 16 ticks shift right one bit, tx <= next LSB; after DBIT bits, state <= STOP, tx <= 1.
REQ-020 STOP: after SB_TICK ticks, state <= IDLE, tx_done_tick = 1 for exactly that one cycle.
REQ-021 Bit order: LSB first; no parity.
REQ-022 Back-to-back: with FIFO non-empty at end of STOP, next fifo_rd asserts in the first IDLE cycle; line stays high for at least 1 clk between frames.
REQ-023 tx_en deasserted mid-frame: current frame completes unchanged; no further fetch until tx_en=1.
REQ-024 fifo_empty or fifo_rd_data changes after fetch SHALL not affect the frame in progress.
REQ-025 Change of dvsr mid-frame affects only the tick spacing from the next counter wrap; no glitch on tx.
REQ-026 Exactly one fifo_rd pulse per transmitted frame; no pop when fifo_empty=1.

Reset
REQ-027 Reset asserted: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, fifo_rd=0, baud counter=0, shift register=0, tick and bit counters=0.
REQ-028 Reset mid-frame: tx returns high immediately; the in-flight byte is discarded and not re-read from the FIFO.
REQ-029 First fetch no earlier than the first rising edge after reset deassertion.

Verification
REQ-030 dvsr=0, FIFO holds 0x55, tx_en=1 -> one fifo_rd pulse; tx low 16 clk, then 1,0,1,0,1,0,1,0 each 16 clk, high 16 clk; tx_done_tick once; total frame 160 clk.
REQ-031 dvsr=3, FIFO holds 0xA3 then 0x0F -> two frames, bit width 64 clk each, data LSB first; second fifo_rd in first IDLE cycle after first tx_done_tick.
REQ-032 fifo_empty=1, tx_en=1 for 1000 clk -> fifo_rd=0, tx=1, tx_busy=0 throughout.
REQ-033 tx_en dropped during DATA of byte 0x81 with FIFO non-empty -> frame completes correctly, no further fifo_rd until tx_en reasserted.
REQ-034 Reset pulsed during bit 3 of a frame -> tx=1 and tx_busy=0 immediately; after release, next FIFO byte sent, no extra pop.
REQ-035 SB_TICK=32, dvsr=0, byte 0xFF -> stop period 32 clk before tx_done_tick.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : UART transmitter that pulls bytes from an upstream FIFO and
//            serialises them LSB first with 16x-oversampled baud ticks.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DBIT-1:0]   fifo_rd_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // The tick counter must reach both the 16-tick bit period and the stop period.
    localparam int TMAX  = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int CNT_W = $clog2(TMAX);
    localparam int NB_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(15);
    localparam logic [CNT_W-1:0] c_stop_last = CNT_W'(SB_TICK - 1);
    localparam logic [NB_W-1:0]  c_data_last = NB_W'(DBIT - 1);

    state_t            r_state;
    logic [DVSR_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [NB_W-1:0]   r_bit_cnt;
    logic [DBIT-1:0]   r_shift;
    logic              r_tx;
    logic              r_done;
    logic              w_tick;
    logic              w_fetch;
    logic [DBIT-1:0]   w_shift_nx;

    // Wrapping on >= lets a smaller divisor take effect cleanly at the next wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt >= dvsr) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    assign w_tick     = (r_baud_cnt == dvsr);
    assign w_fetch    = (r_state == IDLE) && !fifo_empty && tx_en && !reset;
    assign w_shift_nx = r_shift >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fetch) begin
                        r_shift    <= fifo_rd_data;
                        r_tick_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_bit_last) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_tx       <= r_shift[0];
                            r_state    <= DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_bit_last) begin
                            r_tick_cnt <= '0;
                            r_shift    <= w_shift_nx;
                            if (r_bit_cnt == c_data_last) begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_tx      <= w_shift_nx[0];
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_stop_last) begin
                            r_tick_cnt <= '0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_rd      = w_fetch;
    assign tx           = r_tx;
    assign tx_busy      = (r_state != IDLE);
    assign tx_done_tick = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Randomised self-checking bench for fifo_uart_tx against a
//            queue-based FIFO and a bit-period line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int SB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic        tx_en;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd, tx, tx_busy, tx_done_tick;

    logic        reset_nx, tx_en_nx;
    logic [10:0] dvsr_nx;

    logic [10:0] dvsr2 = '0;
    logic        tx_en2 = 1'b1;
    logic        empty2;
    logic [7:0]  data2 = 8'hFF;
    logic        rd2, tx2, busy2, done2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DBIT(8), .SB_TICK(SB), .DVSR_W(11)) u_dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .tx_en(tx_en),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR_W(11)) u_sb32 (
        .clk(clk), .reset(reset), .dvsr(dvsr2), .tx_en(tx_en2),
        .fifo_empty(empty2), .fifo_rd_data(data2),
        .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];
    int         cyc = 0;
    int         pop_cyc = 0;
    logic       in_frame = 1'b0;
    logic       pop_pend = 1'b0;
    logic       pop2_pend = 1'b0;
    logic [7:0] fr_byte = '0;
    int         fr_d = 0;
    int         pushes = 0, pops = 0;
    int         busy2_cnt = 0, done2_cnt = 0, rd2_cnt = 0, low2_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        pushes++;
    endtask

    // Line model: every frame is start, 8 data bits LSB first, stop; each bit
    // is 16*(d+1) clocks, sampled mid-bit, with tick-phase slack at the edges.
    task automatic monitor();
        int t, p, s, half, k, nt, lo, hi;
        logic exp_rd, was_in;
        if (busy2) busy2_cnt++;
        if (done2) done2_cnt++;
        if (!tx2)  low2_cnt++;
        if (rd2) begin rd2_cnt++; pop2_pend = 1'b1; end

        was_in = in_frame;
        p    = 16 * (fr_d + 1);
        s    = SB * (fr_d + 1);
        half = p / 2;
        nt   = 16 * 9 + SB;
        lo   = nt * (fr_d + 1) - fr_d + 1;
        hi   = nt * (fr_d + 1) + 1;
        t    = cyc - pop_cyc;
        if (was_in) begin
            if (tx_done_tick) begin
                chk("done_time", (t >= lo) && (t <= hi), 1'b1);
                in_frame = 1'b0;
            end else if (t > hi) begin
                chk("done_missing", 1'b0, 1'b1);
                in_frame = 1'b0;
            end else begin
                if (t >= half && ((t - half) % p) == 0 && ((t - half) / p) <= 8) begin
                    k = (t - half) / p;
                    chk(k == 0 ? "tx_start" : "tx_data", tx, (k == 0) ? 1'b0 : fr_byte[k-1]);
                    chk("busy_mid", tx_busy, 1'b1);
                end
                if (t == 9 * p + s / 2) chk("tx_stop", tx, 1'b1);
            end
        end else begin
            chk("spurious_done", tx_done_tick, 1'b0);
        end
        if (!in_frame) begin
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", tx_busy, 1'b0);
        end
        exp_rd = !in_frame && tx_en && (q.size() != 0) && !reset;
        chk("fetch", fifo_rd, exp_rd);
        if (fifo_rd && q.size() != 0) begin
            pop_pend = 1'b1;
            pop_cyc  = cyc;
            fr_byte  = q[0];
            fr_d     = int'(dvsr);
            in_frame = 1'b1;
            pops++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (pop_pend) begin void'(q.pop_front()); pop_pend = 1'b0; end
        if (pop2_pend) begin empty2 = 1'b1; pop2_pend = 1'b0; end
        reset        = reset_nx;
        tx_en        = tx_en_nx;
        dvsr         = dvsr_nx;
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() != 0) ? q[0] : 8'h00;
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || in_frame || pop_pend) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < limit, 1'b1);
        repeat (2) cycle();
    endtask

    task automatic wait_t(input int tgt, input logic exact);
        int g = 0;
        while (!(in_frame && ((exact && (cyc - pop_cyc) == tgt) ||
                              (!exact && (cyc - pop_cyc) >= tgt))) && g < 5000) begin
            cycle();
            g++;
        end
        chk("wait_frame", g < 5000, 1'b1);
    endtask

    initial begin
        int p0;
        reset = 1'b1; reset_nx = 1'b1;
        tx_en = 1'b0; tx_en_nx = 1'b0;
        dvsr = '0; dvsr_nx = '0;
        fifo_empty = 1'b1; fifo_rd_data = '0; empty2 = 1'b0;
        repeat (3) cycle();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_rd", fifo_rd, 1'b0);
        chk("rst_done", tx_done_tick, 1'b0);
        chk("rst_rd2", rd2, 1'b0);

        // Single 0x55 frame at the fastest baud.
        reset_nx = 1'b0; tx_en_nx = 1'b1;
        push(8'h55);
        drain(3000);

        // Empty FIFO with transmit enabled: nothing may happen.
        p0 = pops;
        repeat (1000) cycle();
        chk("empty_no_pop", pops - p0, 0);

        // Two back-to-back frames at dvsr=3.
        dvsr_nx = 11'd3;
        repeat (4) cycle();
        push(8'hA3); push(8'h0F);
        drain(4000);

        // Drop tx_en mid-frame: the frame finishes, the next byte waits.
        dvsr_nx = 11'd0;
        repeat (4) cycle();
        push(8'h81); push(8'h42);
        wait_t(3 * 16, 1'b0);
        tx_en_nx = 1'b0;
        repeat (500) cycle();
        chk("hold_q", q.size(), 1);
        chk("hold_in_frame", in_frame, 1'b0);
        tx_en_nx = 1'b1;
        drain(3000);

        // Reset during data bit 3: in-flight byte lost, next byte sent, no re-read.
        dvsr_nx = 11'd1;
        repeat (4) cycle();
        push(8'h3C); push(8'h99);
        wait_t(4 * 32 + 16, 1'b1);
        reset = 1'b1; reset_nx = 1'b1;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_rd", fifo_rd, 1'b0);
        in_frame = 1'b0;
        cycle();
        reset_nx = 1'b0;
        drain(3000);
        chk("midrst_q", q.size(), 0);

        // Randomised frames with random baud and enable gaps.
        for (int it = 0; it < 10; it++) begin
            dvsr_nx = 11'($urandom_range(0, 3));
            repeat (3) cycle();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                tx_en_nx = 1'b0;
                repeat ($urandom_range(1, 200)) cycle();
                tx_en_nx = 1'b1;
            end
            drain(20000);
        end

        chk("pops_eq_pushes", pops, pushes);
        chk("sb32_pops", rd2_cnt, 1);
        chk("sb32_done", done2_cnt, 1);
        chk("sb32_busy_len", busy2_cnt, 16 + 8 * 16 + 32);
        chk("sb32_low_len", low2_cnt, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
